// File: rtl/integ_pkg.sv
`default_nettype none
// ============================================================================
// Module      : integ_pkg
// Description : Shared definitions for the integrator and its stimulus
//               transmitter: FSM state encoding and the common counter width.
// Contents    : stim_state_t  - stimulus transmitter FSM states
//               INTEG_CW      - counter width shared with the integrator
// Revision    : 1.0 - initial release
// ============================================================================
package integ_pkg;

   localparam int INTEG_CW = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_PULSE = 3'd2,
      ST_GAP   = 3'd3,
      ST_DONE  = 3'd4
   } stim_state_t;

endpackage : integ_pkg
`default_nettype wire

// File: rtl/integ_stim_tx_counter.sv
`default_nettype none
// ============================================================================
// Module      : stim_down_counter
// Description : Loadable, enabled down-counter with a zero flag. Load has
//               priority over enable; the count saturates at zero instead of
//               wrapping.
// Ports       : clk        - clock
//               rst        - asynchronous active-high reset (count -> 0)
//               i_load     - load i_load_val on the next edge
//               i_load_val - value to load
//               i_en       - decrement on the next edge
//               o_count    - current count
//               o_zero     - count equals zero
// Revision    : 1.0 - initial release
// ============================================================================
module stim_down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic [W-1:0] o_count,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule : stim_down_counter
`default_nettype wire

// File: rtl/integ_stim_tx.sv
`default_nettype none
// ============================================================================
// Module      : integ_stim_tx
// Description : Stimulus transmitter for the integrator. On an accepted
//               start it issues a one-cycle start strobe, then a programmable
//               number of pulses separated by GAP idle cycles, then a
//               one-cycle completion pulse. Records whether the integrator's
//               saturation flag was seen during the run.
// Ports       : clock   - clock
//               clear   - asynchronous active-high reset
//               start_i - start request (sampled only when idle)
//               count_i - pulse count, latched on an accepted start
//               g_i     - integrator saturation flag
//               s_o     - start strobe
//               x_o     - pulse train
//               busy_o  - run in progress
//               done_o  - one-cycle completion pulse
//               sat_o   - g_i was high during the last run
// Revision    : 1.0 - initial release
// ============================================================================
module integ_stim_tx
   import integ_pkg::*;
#(
   parameter int CW  = INTEG_CW,
   parameter int GAP = 0
) (
   input  logic          clock,
   input  logic          clear,
   input  logic          start_i,
   input  logic [CW-1:0] count_i,
   input  logic          g_i,
   output logic          s_o,
   output logic          x_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          sat_o
);

   // The gap counter is loaded with GAP-1 so that GAP states span exactly
   // GAP cycles (exit when the counter reads zero).
   localparam int          c_GAP_M1   = (GAP > 0) ? GAP - 1 : 0;
   localparam logic [3:0]  c_GAP_LOAD = 4'(c_GAP_M1);

   stim_state_t   r_state;
   logic          r_s;
   logic          r_x;
   logic          r_busy;
   logic          r_done;
   logic          r_sat;

   logic          w_accept;
   logic [CW-1:0] w_pulse_cnt;
   logic          w_pulse_zero;
   logic          w_last_pulse;
   logic [3:0]    w_gap_cnt_unused;
   logic          w_gap_zero;

   assign w_accept     = (r_state == ST_IDLE) && start_i;
   // Decision in PULSE uses the pre-decrement value: a count of one means
   // this is the final pulse.
   assign w_last_pulse = (w_pulse_cnt == CW'(1));

   stim_down_counter #(.W(CW)) u_pulse_cnt (
      .clk        (clock),
      .rst        (clear),
      .i_load     (w_accept),
      .i_load_val (count_i),
      .i_en       (r_state == ST_PULSE),
      .o_count    (w_pulse_cnt),
      .o_zero     (w_pulse_zero)
   );

   stim_down_counter #(.W(4)) u_gap_cnt (
      .clk        (clock),
      .rst        (clear),
      .i_load     (r_state == ST_PULSE),
      .i_load_val (c_GAP_LOAD),
      .i_en       (r_state == ST_GAP),
      .o_count    (w_gap_cnt_unused),
      .o_zero     (w_gap_zero)
   );

   // Outputs are registered alongside the state: each branch sets the
   // output values that belong to the state being entered.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_state <= ST_IDLE;
         r_s     <= 1'b0;
         r_x     <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sat   <= 1'b0;
      end else begin
         r_s    <= 1'b0;
         r_x    <= 1'b0;
         r_done <= 1'b0;
         if ((r_state != ST_IDLE) && g_i) begin
            r_sat <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  r_state <= ST_START;
                  r_s     <= 1'b1;
                  r_busy  <= 1'b1;
                  r_sat   <= 1'b0;
               end
            end
            ST_START: begin
               if (w_pulse_zero) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= ST_PULSE;
                  r_x     <= 1'b1;
               end
            end
            ST_PULSE: begin
               if (w_last_pulse) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else if (GAP > 0) begin
                  r_state <= ST_GAP;
               end else begin
                  r_state <= ST_PULSE;
                  r_x     <= 1'b1;
               end
            end
            ST_GAP: begin
               if (w_gap_zero) begin
                  r_state <= ST_PULSE;
                  r_x     <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign s_o    = r_s;
   assign x_o    = r_x;
   assign busy_o = r_busy;
   assign done_o = r_done;
   assign sat_o  = r_sat;

endmodule : integ_stim_tx
`default_nettype wire

// File: tb/tb_integ_stim_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_integ_stim_tx
// Description : Self-checking bench for integ_stim_tx. Two instances are
//               driven from shared inputs: one with GAP=0, one with GAP=2.
//               A cycle-position model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_integ_stim_tx;
   import integ_pkg::*;

   localparam int CW = INTEG_CW;

   logic          clock = 1'b0;
   logic          clear = 1'b1;
   logic          start_i = 1'b0;
   logic [CW-1:0] count_i = '0;
   logic          g_rand = 1'b0;
   logic          use_integ = 1'b0;
   logic          g_i;
   logic [1:0]    s_o, x_o, busy_o, done_o, sat_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   integ_stim_tx #(.CW(CW), .GAP(0)) u_dut0 (
      .clock(clock), .clear(clear), .start_i(start_i), .count_i(count_i),
      .g_i(g_i), .s_o(s_o[0]), .x_o(x_o[0]), .busy_o(busy_o[0]),
      .done_o(done_o[0]), .sat_o(sat_o[0])
   );

   integ_stim_tx #(.CW(CW), .GAP(2)) u_dut2 (
      .clock(clock), .clear(clear), .start_i(start_i), .count_i(count_i),
      .g_i(g_i), .s_o(s_o[1]), .x_o(x_o[1]), .busy_o(busy_o[1]),
      .done_o(done_o[1]), .sat_o(sat_o[1])
   );

   // Simple integrator stand-in: counts pulses of the GAP=0 instance and
   // raises G once 15 have been seen; cleared on an accepted start.
   logic [3:0] icnt = 4'd0;
   always @(posedge clock) begin
      if (start_i && !busy_o[0]) icnt <= 4'd0;
      else if (x_o[0] && icnt != 4'd15) icnt <= icnt + 4'd1;
   end
   assign g_i = use_integ ? (icnt == 4'd15) : g_rand;

   // ---------------- behavioural model ----------------
   function automatic int gap_of(int i);
      return (i == 0) ? 0 : 2;
   endfunction

   function automatic int run_len(int nn, int g);
      return (nn == 0) ? 2 : 2 + nn + (nn - 1) * g;
   endfunction

   int m_t [2] = '{0, 0};
   int m_n [2] = '{0, 0};
   bit m_act [2] = '{1'b0, 1'b0};
   bit m_sat [2] = '{1'b0, 1'b0};

   always @(posedge clock or posedge clear) begin
      for (int i = 0; i < 2; i++) begin
         if (clear) begin
            m_act[i] <= 1'b0;
            m_t[i]   <= 0;
            m_sat[i] <= 1'b0;
         end else if (m_act[i]) begin
            if (g_i) m_sat[i] <= 1'b1;
            if (m_t[i] == run_len(m_n[i], gap_of(i)) - 1) m_act[i] <= 1'b0;
            else m_t[i] <= m_t[i] + 1;
         end else if (start_i) begin
            m_act[i] <= 1'b1;
            m_t[i]   <= 0;
            m_n[i]   <= int'(count_i);
            m_sat[i] <= 1'b0;
         end
      end
   end

   // {busy, s, x, done, sat}
   function automatic logic [4:0] model_out(int i);
      int  len;
      int  t;
      bit  a;
      int  g;
      logic [4:0] r;
      g   = gap_of(i);
      len = run_len(m_n[i], g);
      t   = m_t[i];
      a   = m_act[i];
      r[4] = a;
      r[3] = a && (t == 0);
      r[2] = a && (t >= 1) && (t < len - 1) && (((t - 1) % (g + 1)) == 0);
      r[1] = a && (t == len - 1);
      r[0] = m_sat[i];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clock) begin
      for (int i = 0; i < 2; i++) begin
         chk((i == 0) ? "model_gap0" : "model_gap2",
             {27'd0, busy_o[i], s_o[i], x_o[i], done_o[i], sat_o[i]},
             {27'd0, model_out(i)});
      end
   end

   // Pulse / done tallies for window-based checks.
   int pulses [2] = '{0, 0};
   int dones  [2] = '{0, 0};
   always @(negedge clock) begin
      for (int i = 0; i < 2; i++) begin
         if (x_o[i]) pulses[i] = pulses[i] + 1;
         if (done_o[i]) dones[i] = dones[i] + 1;
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [31:0] cs [2];
   logic [31:0] cx [2];
   logic [31:0] cd [2];
   logic [31:0] cb [2];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_start(input logic [CW-1:0] cnt);
      start_i = 1'b1;
      count_i = cnt;
      tick();
      start_i = 1'b0;
      count_i = CW'($urandom);
   endtask

   // Capture 12 cycles starting with the cycle after the current edge.
   task automatic capture();
      for (int i = 0; i < 2; i++) begin
         cs[i] = '0; cx[i] = '0; cd[i] = '0; cb[i] = '0;
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         for (int i = 0; i < 2; i++) begin
            cs[i][c] = s_o[i];
            cx[i][c] = x_o[i];
            cd[i][c] = done_o[i];
            cb[i][c] = busy_o[i];
         end
      end
   endtask

   int  seen;
   bit  got_done;

   initial begin
      repeat (2) tick();
      clear = 1'b0;
      tick();
      chk("reset_outputs", {22'd0, busy_o, s_o, x_o, done_o, sat_o}, 32'd0);

      // Basic and gapped burst, count 3.
      do_start(4'd3);
      capture();
      chk("basic_s",    cs[0], 32'h001);
      chk("basic_x",    cx[0], 32'h00E);
      chk("basic_done", cd[0], 32'h010);
      chk("basic_busy", cb[0], 32'h01F);
      chk("gap_x",      cx[1], 32'h092);
      chk("gap_done",   cd[1], 32'h100);
      chk("gap_busy",   cb[1], 32'h1FF);

      // Zero count.
      tick();
      do_start(4'd0);
      capture();
      for (int i = 0; i < 2; i++) begin
         chk("zero_s",    cs[i], 32'h001);
         chk("zero_x",    cx[i], 32'h000);
         chk("zero_done", cd[i], 32'h002);
         chk("zero_busy", cb[i], 32'h003);
      end

      // Start while busy is ignored.
      tick();
      pulses[0] = 0; pulses[1] = 0;
      do_start(4'd5);
      tick(); tick();
      start_i = 1'b1; count_i = 4'd9;
      tick();
      start_i = 1'b0;
      repeat (20) tick();
      chk("busy_start_pulses0", 32'(pulses[0]), 32'd5);
      chk("busy_start_pulses2", 32'(pulses[1]), 32'd5);

      // Back-to-back runs with start held high.
      start_i = 1'b1; count_i = 4'd1;
      tick();
      capture();
      start_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("b2b_s",    cs[i], 32'h111);
         chk("b2b_x",    cx[i], 32'h222);
         chk("b2b_done", cd[i], 32'h444);
      end
      repeat (6) tick();

      // Reset mid-run at the third pulse.
      pulses[0] = 0; pulses[1] = 0;
      dones[0] = 0; dones[1] = 0;
      do_start(4'd8);
      seen = 0;
      for (int c = 0; c < 20 && seen < 3; c++) begin
         @(negedge clock);
         if (x_o[0]) seen++;
      end
      chk("midrun_third_pulse", 32'(seen), 32'd3);
      #1 clear = 1'b1;
      #1 chk("midrun_async_clear", {22'd0, busy_o, s_o, x_o, done_o, sat_o}, 32'd0);
      tick(); tick();
      clear = 1'b0;
      chk("midrun_no_done", 32'(dones[0] + dones[1]), 32'd0);
      pulses[0] = 0; pulses[1] = 0;
      do_start(4'd2);
      repeat (15) tick();
      chk("after_clear_pulses0", 32'(pulses[0]), 32'd2);
      chk("after_clear_pulses2", 32'(pulses[1]), 32'd2);
      chk("after_clear_done", 32'(dones[0] + dones[1]), 32'd2);

      // Saturation with the integrator stand-in attached.
      use_integ = 1'b1;
      do_start(4'd15);
      got_done = 1'b0;
      for (int c = 0; c < 40 && !got_done; c++) begin
         @(negedge clock);
         if (done_o[0]) got_done = 1'b1;
      end
      chk("sat_done_seen", {31'd0, got_done}, 32'd1);
      @(negedge clock);
      chk("sat_after_done", {31'd0, sat_o[0]}, 32'd1);
      repeat (5) @(negedge clock);
      chk("sat_held", {31'd0, sat_o[0]}, 32'd1);
      repeat (40) tick();
      do_start(4'd1);
      @(negedge clock);
      chk("sat_cleared_by_start", {30'd0, sat_o}, 32'd0);
      use_integ = 1'b0;
      repeat (10) tick();

      // Randomized traffic with occasional asynchronous clears.
      for (int c = 0; c < 3000; c++) begin
         start_i = ($urandom_range(0, 3) == 0);
         count_i = CW'($urandom);
         g_rand  = ($urandom_range(0, 15) == 0);
         clear   = ($urandom_range(0, 199) == 0);
         tick();
      end
      clear = 1'b0;
      start_i = 1'b0;
      repeat (40) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_integ_stim_tx
`default_nettype wire
